// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit RISC CPU: opcodes, sequencer state
// encoding, strobe bundle and the ALUOP membership test.
package cpu_pkg;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  typedef enum logic [3:0] {
    ST_INST_ADDR  = 4'd0,
    ST_INST_FETCH = 4'd1,
    ST_INST_LOAD  = 4'd2,
    ST_IDLE       = 4'd3,
    ST_OP_ADDR    = 4'd4,
    ST_OP_FETCH   = 4'd5,
    ST_ALU_OP     = 4'd6,
    ST_STORE      = 4'd7,
    ST_HALTED     = 4'd8
  } state_e;

  typedef struct packed {
    logic sel;
    logic rd;
    logic wr;
    logic ld_ir;
    logic inc_pc;
    logic ld_pc;
    logic ld_ac;
    logic data_e;
    logic halt;
  } strobe_t;

  // Instructions whose result comes back through the accumulator.
  function automatic logic is_aluop(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Sequencer <-> datapath signal bundle. The step input exists only when
// CPU_SEQ_STEP_EN is defined.
interface cpu_sequencer_if;
  logic [2:0] opcode;
  logic       zero;
`ifdef CPU_SEQ_STEP_EN
  logic       step;
`endif
  logic sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt;

`ifdef CPU_SEQ_STEP_EN
  modport master (input opcode, zero, step,
                  output sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt);
  modport slave  (output opcode, zero, step,
                  input sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt);
`else
  modport master (input opcode, zero,
                  output sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt);
  modport slave  (output opcode, zero,
                  input sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt);
`endif
endinterface

// File: rtl/cpu_seq_decode.sv
// Purely combinational state/opcode/zero -> datapath strobe decode.
module cpu_seq_decode
  import cpu_pkg::*;
(
  input  state_e     state,
  input  logic [2:0] opcode,
  input  logic       zero,
  output strobe_t    strb
);

  logic aluop;
  assign aluop = is_aluop(opcode);

  always_comb begin
    strb = '0;
    unique case (state)
      ST_INST_ADDR:  strb.sel = 1'b1;
      ST_INST_FETCH: begin strb.sel = 1'b1; strb.rd = 1'b1; end
      ST_INST_LOAD,
      ST_IDLE: begin
        strb.sel   = 1'b1;
        strb.rd    = 1'b1;
        strb.ld_ir = 1'b1;
      end
      ST_OP_ADDR: begin
        strb.inc_pc = 1'b1;
        strb.halt   = (opcode == OP_HLT);
      end
      ST_OP_FETCH: strb.rd = aluop;
      ST_ALU_OP: begin
        strb.rd     = aluop;
        strb.inc_pc = (opcode == OP_SKZ) && zero;
        strb.ld_pc  = (opcode == OP_JMP);
        strb.data_e = (opcode == OP_STO);
      end
      // wr only ever coincides with data_e, and never with rd (STO is not an ALUOP)
      ST_STORE: begin
        strb.rd     = aluop;
        strb.ld_ac  = aluop;
        strb.ld_pc  = (opcode == OP_JMP);
        strb.wr     = (opcode == OP_STO);
        strb.data_e = (opcode == OP_STO);
      end
      ST_HALTED: strb.halt = 1'b1;
      default: strb = '0;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Eight-phase instruction sequencer: state register + next-state logic.
// Optional single-step hold in INST_ADDR under CPU_SEQ_STEP_EN.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int OP_WIDTH = 3
) (
  input logic             clk,
  input logic             rst,
  cpu_sequencer_if.master bus
);

  state_e                state_q, state_d;
  strobe_t               strb;
  logic [OP_WIDTH-1:0]   opcode;

  assign opcode = bus.opcode;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
`ifdef CPU_SEQ_STEP_EN
      ST_INST_ADDR:  state_d = bus.step ? ST_INST_FETCH : ST_INST_ADDR;
`else
      ST_INST_ADDR:  state_d = ST_INST_FETCH;
`endif
      ST_INST_FETCH: state_d = ST_INST_LOAD;
      ST_INST_LOAD:  state_d = ST_IDLE;
      ST_IDLE:       state_d = ST_OP_ADDR;
      ST_OP_ADDR:    state_d = (opcode == OP_HLT) ? ST_HALTED : ST_OP_FETCH;
      ST_OP_FETCH:   state_d = ST_ALU_OP;
      ST_ALU_OP:     state_d = ST_STORE;
      ST_STORE:      state_d = ST_INST_ADDR;
      ST_HALTED:     state_d = ST_HALTED;
      default:       state_d = ST_INST_ADDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_INST_ADDR;
    else     state_q <= state_d;
  end

  cpu_seq_decode u_decode (
    .state  (state_q),
    .opcode (opcode),
    .zero   (bus.zero),
    .strb   (strb)
  );

  assign bus.sel    = strb.sel;
  assign bus.rd     = strb.rd;
  assign bus.wr     = strb.wr;
  assign bus.ld_ir  = strb.ld_ir;
  assign bus.inc_pc = strb.inc_pc;
  assign bus.ld_pc  = strb.ld_pc;
  assign bus.ld_ac  = strb.ld_ac;
  assign bus.data_e = strb.data_e;
  assign bus.halt   = strb.halt;

endmodule
